// File: rtl/l1_refill_ctrl_if.sv
// Bus bundle between the L1 refill controller and its environment
// (core, address decoder, next memory level, data RAM).
// The master modport is the environment side; the slave modport is the controller.
interface l1_refill_ctrl_if #(
    parameter int unsigned SET_NUMBER   = 8,
    parameter int unsigned BLOCK_NUMBER = 128,
    parameter int unsigned BLOCK_SIZE   = 32,
    parameter int unsigned ADDR_WIDTH   = 32
);
    localparam int unsigned SET_W     = $clog2(SET_NUMBER);
    localparam int unsigned IDX_W     = $clog2(BLOCK_NUMBER) - SET_W;
    localparam int unsigned OFF_W     = $clog2(BLOCK_SIZE);
    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - (OFF_W + 2) - IDX_W;
    localparam int unsigned DWA_W     = SET_W + IDX_W + OFF_W;

    logic                  core_req_val;
    logic [ADDR_WIDTH-1:0] core_req_addr;
    logic                  core_stall;
    logic                  hit;
    logic                  mem_req_val;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_rdy;
    logic                  mem_rsp_val;
    logic [31:0]           mem_rsp_data;
    logic                  data_wr_val;
    logic [DWA_W-1:0]      data_wr_addr;
    logic [31:0]           data_wr_data;
    logic                  tag_wr_val;
    logic [ADDR_WIDTH-1:0] tag_wr_addr;
    logic [TAG_WIDTH-1:0]  tag_wr_data;
    logic                  refill_done;

    modport master (
        output core_req_val, core_req_addr, hit, mem_req_rdy, mem_rsp_val, mem_rsp_data,
        input  core_stall, mem_req_val, mem_req_addr, data_wr_val, data_wr_addr, data_wr_data,
        input  tag_wr_val, tag_wr_addr, tag_wr_data, refill_done
    );

    modport slave (
        input  core_req_val, core_req_addr, hit, mem_req_rdy, mem_rsp_val, mem_rsp_data,
        output core_stall, mem_req_val, mem_req_addr, data_wr_val, data_wr_addr, data_wr_data,
        output tag_wr_val, tag_wr_addr, tag_wr_data, refill_done
    );
endinterface

// File: rtl/l1_refill_ctrl.sv
// L1 miss-handling controller: latches a core request, samples the decoder hit one
// cycle later and, on a miss, fetches the full line into a round-robin victim set,
// writes the tag through the decoder and replays the lookup.
// Optional feature macro: L1_REFILL_CRITICAL_WORD_FIRST_EN (requested word returned
// first, burst wraps, core released on the first beat, no replay).
module l1_refill_ctrl #(
    parameter int unsigned SET_NUMBER   = 8,
    parameter int unsigned BLOCK_NUMBER = 128,
    parameter int unsigned BLOCK_SIZE   = 32,
    parameter int unsigned ADDR_WIDTH   = 32
) (
    input logic          clk,
    input logic          rst_n,
    l1_refill_ctrl_if.slave bus_io
);
    localparam int unsigned SET_W     = $clog2(SET_NUMBER);
    localparam int unsigned IDX_W     = $clog2(BLOCK_NUMBER) - SET_W;
    localparam int unsigned OFF_W     = $clog2(BLOCK_SIZE);
    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - (OFF_W + 2) - IDX_W;
    localparam int unsigned TWA_W     = TAG_WIDTH + SET_W + IDX_W + OFF_W + 2;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMemReq,
        StFill,
        StTagWr,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SET_W-1:0]      victim_q, victim_d;
    logic [OFF_W-1:0]      cnt_q, cnt_d;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [TWA_W-1:0]      tag_addr_full;
    logic                  last_beat;

    assign req_idx = addr_q[OFF_W+2+IDX_W-1:OFF_W+2];
    assign req_tag = addr_q[ADDR_WIDTH-1:ADDR_WIDTH-TAG_WIDTH];

    // Decoder layout {tag, set, index, offset}; the address keeps its low ADDR_WIDTH bits.
    assign tag_addr_full = {req_tag, victim_q, req_idx, {(OFF_W + 2){1'b0}}};

`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
    logic [OFF_W-1:0] beat_q, beat_d;
    logic             first_beat;
    logic [1:0]       unused_addr_lo;

    // Burst starts at the requested word; beats are counted separately from the word.
    assign line_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign last_beat      = (beat_q == OFF_W'(BLOCK_SIZE - 1));
    assign first_beat     = (beat_q == '0);
    assign unused_addr_lo = addr_q[1:0];

    // Beat counter for the wrapping burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end
`else
    logic [OFF_W+1:0] unused_addr_lo;

    assign line_addr      = {addr_q[ADDR_WIDTH-1:OFF_W+2], {(OFF_W + 2){1'b0}}};
    assign last_beat      = (cnt_q == OFF_W'(BLOCK_SIZE - 1));
    assign unused_addr_lo = addr_q[OFF_W+1:0];
`endif

    // State, latched address, victim pointer and word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            victim_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            victim_q <= victim_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and output decode; data/address outputs are zero unless their strobe is set.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        victim_d = victim_q;
        cnt_d    = cnt_q;
`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
        beat_d   = beat_q;
`endif
        bus_io.core_stall   = 1'b1;
        bus_io.mem_req_val  = 1'b0;
        bus_io.mem_req_addr = '0;
        bus_io.data_wr_val  = 1'b0;
        bus_io.data_wr_addr = '0;
        bus_io.data_wr_data = '0;
        bus_io.tag_wr_val   = 1'b0;
        bus_io.tag_wr_addr  = '0;
        bus_io.tag_wr_data  = '0;
        bus_io.refill_done  = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus_io.core_stall = 1'b0;
                if (bus_io.core_req_val) begin
                    addr_d  = bus_io.core_req_addr;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (bus_io.hit) begin
                    bus_io.core_stall = 1'b0;
                    if (bus_io.core_req_val) begin
                        addr_d = bus_io.core_req_addr;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    state_d = StMemReq;
                end
            end
            StMemReq: begin
                bus_io.mem_req_val  = 1'b1;
                bus_io.mem_req_addr = line_addr;
                if (bus_io.mem_req_rdy) begin
                    state_d = StFill;
`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
                    cnt_d  = addr_q[OFF_W+1:2];
                    beat_d = '0;
`else
                    cnt_d  = '0;
`endif
                end
            end
            StFill: begin
                if (bus_io.mem_rsp_val) begin
                    bus_io.data_wr_val  = 1'b1;
                    bus_io.data_wr_addr = {victim_q, req_idx, cnt_q};
                    bus_io.data_wr_data = bus_io.mem_rsp_data;
                    cnt_d               = cnt_q + 1'b1;
`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
                    beat_d = beat_q + 1'b1;
                    // Critical word is on the bus now: release the core for this cycle.
                    if (first_beat) begin
                        bus_io.core_stall  = 1'b0;
                        bus_io.refill_done = 1'b1;
                    end
`endif
                    if (last_beat) begin
                        state_d = StTagWr;
                    end
                end
            end
            StTagWr: begin
                bus_io.tag_wr_val  = 1'b1;
                bus_io.tag_wr_addr = ADDR_WIDTH'(tag_addr_full);
                bus_io.tag_wr_data = req_tag;
                victim_d           = victim_q + 1'b1;
`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
                state_d = StIdle;
`else
                state_d = StDone;
`endif
            end
            StDone: begin
                bus_io.refill_done = 1'b1;
                state_d            = StLookup;
            end
            default: state_d = StIdle;
        endcase
    end
endmodule
